multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Multicycle sequencer for the RV32I subset lw, sw, beq, add, sub, and, or. It replaces single-cycle control with a Moore FSM. The FSM drives a shared-memory datapath (one memory port for instruction and data, one ALU, IR/PC/ALUOut registers) and tolerates variable memory latency through a ready handshake. ALUOP encoding matches the existing control unit: 0010 add, 0110 sub, 0000 and, 0001 or, 1111 unknown.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for MEM_READY in a memory state before entering ERROR (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
INSTRUCTION  input  32  IR contents; opcode [6:0], funct3 [14:12], funct7 bit [30]
ZERO  input  1  ALU zero flag
MEM_READY  input  1  memory completes the current access this cycle
PCWRITE  output  1  load PC from ALU result (fetch) or ALUOut (branch)
PCSRC  output  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
IRWRITE  output  1  load IR from memory read data
ADRSRC  output  1  memory address: 0 = PC, 1 = ALUOut
MEMTOREAD  output  1  memory read request
MEMWRITE  output  1  memory write request
REGWRITE  output  1  register file write enable
ALUSRCA  output  2  00 = PC, 01 = oldPC, 10 = rs1
ALUSRCB  output  2  00 = rs2, 01 = imm, 10 = constant 4
RESULTSRC  output  2  00 = ALUOut, 01 = memory data, 10 = ALU result
ALUOP  output  4  ALU control
ILLEGAL  output  1  sticky error flag
STATE  output  4  current state (debug)
INSTR_COUNT  output  CNT_W  retired instructions, wraps

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWR=6, EXECUTE=7, ALUWB=8, BEQ=9, ERROR=10.
- Reset (async, RST_N=0): state=IDLE, wait counter=0, INSTR_COUNT=0, ILLEGAL=0. All outputs are 0, including ALUOP=0000 and STATE=0.
- Outputs are decoded from the state. Exceptions: PCWRITE and IRWRITE in FETCH are gated by MEM_READY, and PCWRITE in BEQ is gated by ZERO.
- Any output not listed for a state is 0.
- IDLE: go to FETCH unconditionally after 1 cycle.
- FETCH: MEMTOREAD=1, ADRSRC=0, ALUSRCA=00, ALUSRCB=10, ALUOP=0010, RESULTSRC=10. Hold while MEM_READY=0. When MEM_READY=1: IRWRITE=1, PCWRITE=1, go to DECODE.
- DECODE: ALUSRCA=01, ALUSRCB=01, ALUOP=0010 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTE
  - 1100011 -> BEQ
  - any other opcode -> ERROR
- MEMADR: ALUSRCA=10, ALUSRCB=01, ALUOP=0010. Go to MEMREAD for lw, MEMWR for sw.
- MEMREAD: MEMTOREAD=1, ADRSRC=1. Hold until MEM_READY, then go to MEMWB.
- MEMWB: RESULTSRC=01, REGWRITE=1. Go to FETCH.
- MEMWR: MEMWRITE=1, ADRSRC=1. Hold until MEM_READY, then go to FETCH.
- EXECUTE: ALUSRCA=10, ALUSRCB=00. ALUOP from {funct7[5], funct3}:
  - 0_000 -> 0010 (add)
  - 1_000 -> 0110 (sub)
  - 0_110 -> 0001 (or)
  - 0_111 -> 0000 (and)
  - any other combination: ALUOP=1111, go to ERROR, no register write
  - Otherwise go to ALUWB.
- ALUWB: RESULTSRC=00, REGWRITE=1. Go to FETCH.
- BEQ: ALUSRCA=10, ALUSRCB=00, ALUOP=0110, PCSRC=1, PCWRITE=ZERO. Go to FETCH.
- ERROR: all strobes 0, ALUOP=1111, ILLEGAL=1. Only reset exits this state.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD and MEMWR; increments each cycle MEM_READY=0 in those states.
  - If the counter reaches MEM_TIMEOUT while MEM_READY=0, go to ERROR on the next edge.
  - MEM_READY=1 in the same cycle as the limit counts as success.
- INSTR_COUNT increments by 1 on every transition MEMWB->FETCH, MEMWR->FETCH, ALUWB->FETCH and BEQ->FETCH. It wraps 2^CNT_W-1 -> 0.
- Latency with zero-wait memory: lw 5 cycles, sw 4, R-type 4, beq 3.
- INSTRUCTION is considered valid from DECODE onward; the FSM never samples it in FETCH.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. No partial MEMWRITE or REGWRITE pulse is issued after RST_N falls.

Test Plan:
- Reset, then lw with MEM_READY=1 always -> STATE sequence 0,1,2,3,4,5,1. REGWRITE=1 only in MEMWB with RESULTSRC=01. INSTR_COUNT=1.
- sw with MEM_READY low for 3 cycles in MEMWR -> MEMWRITE=1 and ADRSRC=1 held 4 cycles, no REGWRITE, then FETCH.
- beq with ZERO=1, then with ZERO=0 -> PCWRITE=1 and PCSRC=1 in BEQ for the first; PCWRITE=0 for the second. ALUOP=0110 in both.
- R-type sub (bit30=1, funct3=000) and or (funct3=110) -> ALUOP 0110 and 0001 in EXECUTE, REGWRITE in ALUWB.
- Opcode 0000000 -> ERROR after DECODE, ILLEGAL=1, ALUOP=1111, state held. Separately: MEM_READY held 0 in FETCH for MEM_TIMEOUT=15 cycles -> ERROR.
- RST_N pulsed low during MEMWR -> outputs 0 asynchronously, STATE=0, INSTR_COUNT=0, FETCH after release.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm
//  Purpose  : Moore sequencer for a multicycle RV32I subset datapath
//             (lw, sw, beq, add, sub, and, or). It uses one shared memory
//             port, one ALU and IR/PC/ALUOut registers. Memory accesses
//             complete on MEM_READY, which may arrive after a variable delay.
//             A wait counter gives up after MEM_TIMEOUT cycles without
//             MEM_READY. The FSM then parks in ERROR until reset.
//  Ports    : CLK, RST_N (async, active low)
//             INSTRUCTION  - IR contents, sampled from DECODE onward
//             ZERO         - ALU zero flag (gates PCWRITE in BEQ)
//             MEM_READY    - current memory access completes this cycle
//             PCWRITE/PCSRC/IRWRITE/ADRSRC/MEMTOREAD/MEMWRITE/REGWRITE,
//             ALUSRCA/ALUSRCB/RESULTSRC/ALUOP - datapath controls
//             ILLEGAL      - sticky error flag (set in ERROR)
//             STATE        - current state (debug)
//             INSTR_COUNT  - retired instruction counter, wraps
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      INSTRUCTION,
  input  logic             ZERO,
  input  logic             MEM_READY,
  output logic             PCWRITE,
  output logic             PCSRC,
  output logic             IRWRITE,
  output logic             ADRSRC,
  output logic             MEMTOREAD,
  output logic             MEMWRITE,
  output logic             REGWRITE,
  output logic [1:0]       ALUSRCA,
  output logic [1:0]       ALUSRCB,
  output logic [1:0]       RESULTSRC,
  output logic [3:0]       ALUOP,
  output logic             ILLEGAL,
  output logic [3:0]       STATE,
  output logic [CNT_W-1:0] INSTR_COUNT
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMREAD = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BEQ     = 4'd9,
    S_ERROR   = 4'd10
  } state_t;

  localparam logic [6:0] C_OP_LW    = 7'b0000011;
  localparam logic [6:0] C_OP_SW    = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
  localparam logic [6:0] C_OP_BEQ   = 7'b1100011;

  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_BAD = 4'b1111;

  // The counter holds the number of MEM_READY-low cycles already spent. If
  // this cycle is also low and it is the MEM_TIMEOUT-th such cycle, give up.
  localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [6:0] w_opcode;
  logic [3:0] w_funct;
  logic       w_timeout;
  logic       w_wait_state;
  logic       w_rtype_ok;
  logic [3:0] w_rtype_op;
  logic       w_unused_instr;

  assign w_opcode       = INSTRUCTION[6:0];
  assign w_funct        = {INSTRUCTION[30], INSTRUCTION[14:12]};
  assign w_unused_instr = ^{INSTRUCTION[31], INSTRUCTION[29:15], INSTRUCTION[11:7]};

  assign w_wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWR);
  assign w_timeout    = w_wait_state && !MEM_READY && (wait_q == C_WAIT_LAST);

  // R-type function decode: {funct7[5], funct3}
  always_comb begin
    w_rtype_ok = 1'b1;
    w_rtype_op = C_ALU_BAD;
    case (w_funct)
      4'b0000: w_rtype_op = C_ALU_ADD;
      4'b1000: w_rtype_op = C_ALU_SUB;
      4'b0110: w_rtype_op = C_ALU_OR;
      4'b0111: w_rtype_op = C_ALU_AND;
      default: w_rtype_ok = 1'b0;
    endcase
  end

  // State register, wait counter and retired-instruction counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // Next-state, counters and Moore outputs
  always_comb begin
    state_d   = state_q;
    PCWRITE   = 1'b0;
    PCSRC     = 1'b0;
    IRWRITE   = 1'b0;
    ADRSRC    = 1'b0;
    MEMTOREAD = 1'b0;
    MEMWRITE  = 1'b0;
    REGWRITE  = 1'b0;
    ALUSRCA   = 2'b00;
    ALUSRCB   = 2'b00;
    RESULTSRC = 2'b00;
    ALUOP     = 4'b0000;
    ILLEGAL   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        MEMTOREAD = 1'b1;
        ALUSRCB   = 2'b10;
        ALUOP     = C_ALU_ADD;
        RESULTSRC = 2'b10;
        IRWRITE   = MEM_READY;
        PCWRITE   = MEM_READY;
        if (MEM_READY)      state_d = S_DECODE;
        else if (w_timeout) state_d = S_ERROR;
      end

      S_DECODE: begin
        ALUSRCA = 2'b01;
        ALUSRCB = 2'b01;
        ALUOP   = C_ALU_ADD;
        case (w_opcode)
          C_OP_LW, C_OP_SW: state_d = S_MEMADR;
          C_OP_RTYPE:       state_d = S_EXECUTE;
          C_OP_BEQ:         state_d = S_BEQ;
          default:          state_d = S_ERROR;
        endcase
      end

      S_MEMADR: begin
        ALUSRCA = 2'b10;
        ALUSRCB = 2'b01;
        ALUOP   = C_ALU_ADD;
        if (w_opcode == C_OP_LW)      state_d = S_MEMREAD;
        else if (w_opcode == C_OP_SW) state_d = S_MEMWR;
        else                          state_d = S_ERROR;
      end

      S_MEMREAD: begin
        MEMTOREAD = 1'b1;
        ADRSRC    = 1'b1;
        if (MEM_READY)      state_d = S_MEMWB;
        else if (w_timeout) state_d = S_ERROR;
      end

      S_MEMWB: begin
        RESULTSRC = 2'b01;
        REGWRITE  = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEMWR: begin
        MEMWRITE = 1'b1;
        ADRSRC   = 1'b1;
        if (MEM_READY)      state_d = S_FETCH;
        else if (w_timeout) state_d = S_ERROR;
      end

      S_EXECUTE: begin
        ALUSRCA = 2'b10;
        ALUOP   = w_rtype_op;
        state_d = w_rtype_ok ? S_ALUWB : S_ERROR;
      end

      S_ALUWB: begin
        REGWRITE = 1'b1;
        state_d  = S_FETCH;
      end

      S_BEQ: begin
        ALUSRCA = 2'b10;
        ALUOP   = C_ALU_SUB;
        PCSRC   = 1'b1;
        PCWRITE = ZERO;
        state_d = S_FETCH;
      end

      S_ERROR: begin
        ALUOP   = C_ALU_BAD;
        ILLEGAL = 1'b1;
      end

      default: state_d = S_ERROR;
    endcase
  end

  // Wait counter restarts whenever the state changes, so every entry into a
  // memory state begins from zero.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = 8'd0;
    else if (w_wait_state && !MEM_READY)
      wait_d = wait_q + 8'd1;
  end

  // An instruction retires when a final state hands control back to FETCH.
  always_comb begin
    count_d = count_q;
    if ((state_d == S_FETCH) &&
        ((state_q == S_MEMWB) || (state_q == S_MEMWR) ||
         (state_q == S_ALUWB) || (state_q == S_BEQ)))
      count_d = count_q + CNT_W'(1);
  end

  assign STATE       = state_q;
  assign INSTR_COUNT = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control_fsm
//  Purpose  : Directed self-checking bench for multicycle_control_fsm.
//             Output vector layout (22 bits, MSB first):
//             STATE[4] PCWRITE PCSRC IRWRITE ADRSRC MEMTOREAD MEMWRITE
//             REGWRITE ALUSRCA[2] ALUSRCB[2] RESULTSRC[2] ALUOP[4] ILLEGAL
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [31:0]   INSTRUCTION = 32'd0;
  logic          ZERO = 1'b0;
  logic          MEM_READY = 1'b0;
  logic          PCWRITE, PCSRC, IRWRITE, ADRSRC, MEMTOREAD, MEMWRITE, REGWRITE;
  logic [1:0]    ALUSRCA, ALUSRCB, RESULTSRC;
  logic [3:0]    ALUOP;
  logic          ILLEGAL;
  logic [3:0]    STATE;
  logic [CW-1:0] INSTR_COUNT;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I_LW   = 32'h00002003;
  localparam logic [31:0] I_SW   = 32'h00002023;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_SUB  = 32'h40000033;
  localparam logic [31:0] I_OR   = 32'h00006033;
  localparam logic [31:0] I_BADF = 32'h00001033;
  localparam logic [31:0] I_BADO = 32'h00000000;

  //                        st    pw   ps   iw   ad   rd   wr   rw   sa    sb    rs    op      il
  localparam logic [21:0] V_IDLE   = {4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,4'h0,1'b0};
  localparam logic [21:0] V_FETCH1 = {4'd1, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,2'd2,2'd2,4'h2,1'b0};
  localparam logic [21:0] V_FETCH0 = {4'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd2,2'd2,4'h2,1'b0};
  localparam logic [21:0] V_DECODE = {4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd1,2'd0,4'h2,1'b0};
  localparam logic [21:0] V_MEMADR = {4'd3, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd1,2'd0,4'h2,1'b0};
  localparam logic [21:0] V_MEMRD  = {4'd4, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,4'h0,1'b0};
  localparam logic [21:0] V_MEMWB  = {4'd5, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd1,4'h0,1'b0};
  localparam logic [21:0] V_MEMWR  = {4'd6, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,4'h0,1'b0};
  localparam logic [21:0] V_EX_SUB = {4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd0,4'h6,1'b0};
  localparam logic [21:0] V_EX_OR  = {4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd0,4'h1,1'b0};
  localparam logic [21:0] V_EX_BAD = {4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd0,4'hF,1'b0};
  localparam logic [21:0] V_ALUWB  = {4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd0,4'h0,1'b0};
  localparam logic [21:0] V_BEQ_Z1 = {4'd9, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd0,4'h6,1'b0};
  localparam logic [21:0] V_BEQ_Z0 = {4'd9, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd0,4'h6,1'b0};
  localparam logic [21:0] V_ERROR  = {4'd10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,4'hF,1'b1};

  multicycle_control_fsm #(
    .MEM_TIMEOUT (15),
    .CNT_W       (CW)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .INSTRUCTION (INSTRUCTION),
    .ZERO        (ZERO),
    .MEM_READY   (MEM_READY),
    .PCWRITE     (PCWRITE),
    .PCSRC       (PCSRC),
    .IRWRITE     (IRWRITE),
    .ADRSRC      (ADRSRC),
    .MEMTOREAD   (MEMTOREAD),
    .MEMWRITE    (MEMWRITE),
    .REGWRITE    (REGWRITE),
    .ALUSRCA     (ALUSRCA),
    .ALUSRCB     (ALUSRCB),
    .RESULTSRC   (RESULTSRC),
    .ALUOP       (ALUOP),
    .ILLEGAL     (ILLEGAL),
    .STATE       (STATE),
    .INSTR_COUNT (INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_vec(input string tag, input logic [21:0] exp);
    logic [21:0] obs;
    obs = {STATE, PCWRITE, PCSRC, IRWRITE, ADRSRC, MEMTOREAD, MEMWRITE, REGWRITE,
           ALUSRCA, ALUSRCB, RESULTSRC, ALUOP, ILLEGAL};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] exp);
    total++;
    assert (INSTR_COUNT === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, INSTR_COUNT, exp);
    end
  endtask

  task automatic do_reset();
    #2 RST_N = 1'b0;
    #1;
    chk_vec("reset_outputs", V_IDLE);
    chk_cnt("reset_count", '0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    // ---- reset state ----
    #2;
    chk_vec("por_idle", V_IDLE);
    chk_cnt("por_count", '0);
    #10 RST_N = 1'b1;
    #1 chk_vec("idle_after_release", V_IDLE);

    // ---- lw, zero-wait: 1,2,3,4,5,1 ----
    MEM_READY   = 1'b1;
    INSTRUCTION = I_LW;
    tick(); chk_vec("lw_fetch", V_FETCH1);
    tick(); chk_vec("lw_decode", V_DECODE);
    tick(); chk_vec("lw_memadr", V_MEMADR);
    tick(); chk_vec("lw_memread", V_MEMRD);
    tick(); chk_vec("lw_memwb", V_MEMWB);
    tick(); chk_vec("lw_back_fetch", V_FETCH1);
    chk_cnt("lw_count", 4'd1);

    // ---- sw with three wait cycles in MEMWR ----
    INSTRUCTION = I_SW;
    tick(); chk_vec("sw_decode", V_DECODE);
    tick(); chk_vec("sw_memadr", V_MEMADR);
    MEM_READY = 1'b0;
    tick(); chk_vec("sw_memwr_w1", V_MEMWR);
    tick(); chk_vec("sw_memwr_w2", V_MEMWR);
    tick(); chk_vec("sw_memwr_w3", V_MEMWR);
    MEM_READY = 1'b1;
    #1 chk_vec("sw_memwr_done", V_MEMWR);
    tick(); chk_vec("sw_back_fetch", V_FETCH1);
    chk_cnt("sw_count", 4'd2);

    // ---- beq taken, then not taken ----
    INSTRUCTION = I_BEQ;
    ZERO = 1'b1;
    tick(); chk_vec("beq1_decode", V_DECODE);
    tick(); chk_vec("beq1_taken", V_BEQ_Z1);
    tick(); chk_vec("beq1_fetch", V_FETCH1);
    chk_cnt("beq1_count", 4'd3);
    ZERO = 1'b0;
    tick(); chk_vec("beq2_decode", V_DECODE);
    tick(); chk_vec("beq2_not_taken", V_BEQ_Z0);
    tick(); chk_cnt("beq2_count", 4'd4);

    // ---- R-type sub and or ----
    INSTRUCTION = I_SUB;
    tick(); chk_vec("sub_decode", V_DECODE);
    tick(); chk_vec("sub_execute", V_EX_SUB);
    tick(); chk_vec("sub_aluwb", V_ALUWB);
    tick(); chk_cnt("sub_count", 4'd5);
    INSTRUCTION = I_OR;
    tick();
    tick(); chk_vec("or_execute", V_EX_OR);
    tick(); chk_vec("or_aluwb", V_ALUWB);
    tick(); chk_vec("or_fetch", V_FETCH1);
    chk_cnt("or_count", 4'd6);

    // ---- reset pulsed while in MEMWR ----
    INSTRUCTION = I_SW;
    tick();
    tick();
    MEM_READY = 1'b0;
    tick(); chk_vec("rst_pre_memwr", V_MEMWR);
    #2 RST_N = 1'b0;
    #1;
    chk_vec("rst_async_outputs", V_IDLE);
    chk_cnt("rst_async_count", '0);
    #2 RST_N = 1'b1;
    tick(); chk_vec("rst_release_fetch", V_FETCH0);

    // ---- fetch timeout: 15 cycles of MEM_READY low ----
    for (int i = 0; i < 14; i++) tick();
    chk_vec("timeout_still_fetch", V_FETCH0);
    tick(); chk_vec("timeout_error", V_ERROR);
    MEM_READY = 1'b1;
    tick(); chk_vec("timeout_error_held", V_ERROR);

    // ---- illegal opcode ----
    do_reset();
    INSTRUCTION = I_BADO;
    chk_vec("badop_fetch", V_FETCH1);
    tick(); chk_vec("badop_decode", V_DECODE);
    tick(); chk_vec("badop_error", V_ERROR);
    tick(); tick(); chk_vec("badop_error_held", V_ERROR);

    // ---- illegal R-type function ----
    do_reset();
    INSTRUCTION = I_BADF;
    tick();
    tick(); chk_vec("badfunct_execute", V_EX_BAD);
    tick(); chk_vec("badfunct_error", V_ERROR);

    // ---- retired counter wrap ----
    do_reset();
    INSTRUCTION = I_BEQ;
    ZERO = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(); tick(); tick();
    end
    chk_cnt("wrap_count_max", 4'd15);
    tick(); tick(); tick();
    chk_cnt("wrap_count_zero", 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
